// File: rtl/noc_pkg.sv
// Shared NoC flit definitions for the network adapter: flit type codes,
// arbiter state encoding and the flit width derivation.
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_PAYLOAD = 2'b00,
    FLIT_HEADER  = 2'b01,
    FLIT_LAST    = 2'b10,
    FLIT_SINGLE  = 2'b11
  } flit_type_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // The type field sits in the flit MSBs, directly above the payload.
  function automatic int nocFlitWidth(int dataWidth, int typeWidth);
    return dataWidth + typeWidth;
  endfunction

endpackage

// File: rtl/noc_rr_select.sv
// Combinational round-robin select: picks the first requester above ptr_i,
// wrapping modulo N_PORTS, and returns it one-hot and as an index.
module noc_rr_select #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = 1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [N_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    int p;
    grant_o = '0;
    idx_o   = '0;
    p       = 0;
    for (int off = N_PORTS; off >= 1; off--) begin
      p = (int'(ptr_i) + off) % N_PORTS;
      if (req_i[p]) begin
        grant_o    = '0;
        grant_o[p] = 1'b1;
        idx_o      = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/noc_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one VC output among N_PORTS
// requesters, with a one-entry full-throughput output register.
module noc_packet_arbiter
  import noc_pkg::*;
#(
  parameter int NOC_FLIT_DATA_WIDTH = 32,
  parameter int NOC_FLIT_TYPE_WIDTH = 2,
  parameter int N_PORTS             = 2,
  localparam int NOC_FLIT_WIDTH     = nocFlitWidth(NOC_FLIT_DATA_WIDTH, NOC_FLIT_TYPE_WIDTH),
  localparam int OWNER_W            = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_sys_n,
  input  logic [N_PORTS*NOC_FLIT_WIDTH-1:0] in_flit,
  input  logic [N_PORTS-1:0]                in_valid,
  output logic [N_PORTS-1:0]                in_ready,
  output logic [NOC_FLIT_WIDTH-1:0]         out_flit,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OWNER_W-1:0]                owner,
  output logic                              trace_pkt_start,
  output logic                              trace_pkt_end,
  output logic                              proto_err
);

  arb_state_e                state_q, state_d;
  logic [OWNER_W-1:0]        rrPtr_q, rrPtr_d;
  logic [OWNER_W-1:0]        owner_q, owner_d;
  logic [NOC_FLIT_WIDTH-1:0] outFlit_q, outFlit_d;
  logic                      outValid_q, outValid_d;
  logic                      traceStart_q, traceStart_d;
  logic                      traceEnd_q, traceEnd_d;
  logic                      protoErr_q, protoErr_d;

  logic [N_PORTS-1:0]        selGrant, grant;
  logic [OWNER_W-1:0]        selIdx, grantIdx;
  logic                      stageAccept, xfer;
  logic [NOC_FLIT_WIDTH-1:0] xferFlit;
  flit_type_e                xferType;

  noc_rr_select #(
    .N_PORTS(N_PORTS),
    .IDX_W  (OWNER_W)
  ) u_rr_select (
    .req_i  (in_valid),
    .ptr_i  (rrPtr_q),
    .grant_o(selGrant),
    .idx_o  (selIdx)
  );

  // While a packet is in flight only its owner may send, valid or not.
  always_comb begin
    stageAccept = !outValid_q || out_ready;
    grant       = selGrant;
    grantIdx    = selIdx;
    if (state_q == ARB_LOCKED) begin
      grant          = '0;
      grant[owner_q] = 1'b1;
      grantIdx       = owner_q;
    end
  end

  assign in_ready = (stageAccept && rst_sys_n) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);
  assign xferFlit = in_flit[int'(grantIdx)*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
  assign xferType = flit_type_e'(xferFlit[NOC_FLIT_WIDTH-1 -: 2]);

  always_comb begin
    state_d      = state_q;
    rrPtr_d      = rrPtr_q;
    owner_d      = owner_q;
    outFlit_d    = outFlit_q;
    outValid_d   = outValid_q;
    traceStart_d = xfer && (xferType == FLIT_HEADER || xferType == FLIT_SINGLE);
    traceEnd_d   = xfer && (xferType == FLIT_LAST || xferType == FLIT_SINGLE);
    protoErr_d   = xfer && (state_q == ARB_IDLE) &&
                   (xferType == FLIT_PAYLOAD || xferType == FLIT_LAST);

    if (xfer) begin
      outFlit_d  = xferFlit;
      outValid_d = 1'b1;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end

    // Stray PAYLOAD/LAST in IDLE are forwarded and treated like a SINGLE.
    if (xfer) begin
      case (state_q)
        ARB_IDLE: begin
          owner_d = grantIdx;
          if (xferType == FLIT_HEADER) state_d = ARB_LOCKED;
          else                         rrPtr_d = grantIdx;
        end
        ARB_LOCKED: begin
          if (xferType == FLIT_LAST) begin
            state_d = ARB_IDLE;
            rrPtr_d = owner_q;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_sys_n) begin
      state_q      <= ARB_IDLE;
      rrPtr_q      <= OWNER_W'(N_PORTS - 1);
      owner_q      <= '0;
      outFlit_q    <= '0;
      outValid_q   <= 1'b0;
      traceStart_q <= 1'b0;
      traceEnd_q   <= 1'b0;
      protoErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rrPtr_q      <= rrPtr_d;
      owner_q      <= owner_d;
      outFlit_q    <= outFlit_d;
      outValid_q   <= outValid_d;
      traceStart_q <= traceStart_d;
      traceEnd_q   <= traceEnd_d;
      protoErr_q   <= protoErr_d;
    end
  end

  assign out_flit        = outFlit_q;
  assign out_valid       = outValid_q;
  assign owner           = owner_q;
  assign trace_pkt_start = traceStart_q;
  assign trace_pkt_end   = traceEnd_q;
  assign proto_err       = protoErr_q;

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// Self-checking bench for noc_packet_arbiter with three ports: directed
// scenarios plus randomized traffic against a cycle-level reference model.
module tb_noc_packet_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int FW = DW + TW;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst_sys_n = 1'b0;
  logic [N*FW-1:0] in_flit = '0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] owner;
  logic          trace_pkt_start, trace_pkt_end, proto_err;

  noc_packet_arbiter #(
    .NOC_FLIT_DATA_WIDTH(DW),
    .NOC_FLIT_TYPE_WIDTH(TW),
    .N_PORTS            (N)
  ) dut (
    .clk            (clk),
    .rst_sys_n      (rst_sys_n),
    .in_flit        (in_flit),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_flit       (out_flit),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .owner          (owner),
    .trace_pkt_start(trace_pkt_start),
    .trace_pkt_end  (trace_pkt_end),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int peSeen = 0;

  logic [FW-1:0] portQ [N][$];
  logic [N-1:0]  holdOff = '0;
  bit randValid  = 1'b0;
  bit randReady  = 1'b0;
  bit fixedReady = 1'b1;
  int grantLog[$];
  int xferCyc[$];

  // Reference model state: packet lock, owner, round-robin pointer, output register.
  bit            mLocked;
  int            mOwner;
  int            mPtr;
  bit            mOutValid;
  logic [FW-1:0] mOutFlit;
  bit            mTs, mTe, mPe;

  function automatic logic [FW-1:0] mkFlit(logic [1:0] t, logic [31:0] d);
    return {t, d};
  endfunction

  task automatic modelReset();
    mLocked   = 1'b0;
    mOwner    = 0;
    mPtr      = N - 1;
    mOutValid = 1'b0;
    mOutFlit  = '0;
    mTs = 1'b0; mTe = 1'b0; mPe = 1'b0;
  endtask

  task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < N; i++) begin
      if (portQ[i].size() != 0) begin
        in_valid[i]         = !holdOff[i];
        in_flit[i*FW +: FW] = portQ[i][0];
      end else begin
        in_valid[i]         = 1'b0;
        in_flit[i*FW +: FW] = '0;
      end
    end
  endtask

  task automatic pushFlit(int port, logic [1:0] t, logic [31:0] d);
    portQ[port].push_back(mkFlit(t, d));
    driveInputs();
  endtask

  function automatic bit queuesBusy();
    for (int i = 0; i < N; i++) if (portQ[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check outputs and in_ready at negedge, advance the model at posedge.
  task automatic applyStimulus();
    int            g;
    bit            found;
    bit            stageAcc;
    bit            xfer;
    logic [N-1:0]  expReady;
    logic [N-1:0]  curValid;
    logic [FW-1:0] f;
    logic [1:0]    t;
    @(negedge clk);
    cyc++;
    checkOutput("out_valid", out_valid, mOutValid);
    checkOutput("out_flit", out_flit, mOutFlit);
    checkOutput("owner", owner, mOwner);
    checkOutput("trace_pkt_start", trace_pkt_start, mTs);
    checkOutput("trace_pkt_end", trace_pkt_end, mTe);
    checkOutput("proto_err", proto_err, mPe);
    if (proto_err === 1'b1) peSeen++;
    curValid = in_valid;
    stageAcc = !mOutValid || out_ready;
    g        = -1;
    expReady = '0;
    if (rst_sys_n) begin
      if (mLocked) g = mOwner;
      else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (mPtr + k) % N;
          if (!found && curValid[p]) begin
            g = p;
            found = 1'b1;
          end
        end
      end
      if (g >= 0 && stageAcc) expReady[g] = 1'b1;
    end
    checkOutput("in_ready", in_ready, expReady);
    xfer = (g >= 0) && expReady[g] && curValid[g];
    f = '0;
    if (xfer) f = portQ[g][0];
    t = f[FW-1 -: 2];
    @(posedge clk);
    if (!rst_sys_n) modelReset();
    else begin
      mTs = xfer && (t == 2'b01 || t == 2'b11);
      mTe = xfer && (t == 2'b10 || t == 2'b11);
      mPe = xfer && !mLocked && (t == 2'b00 || t == 2'b10);
      if (xfer) begin
        grantLog.push_back(g);
        xferCyc.push_back(cyc);
        void'(portQ[g].pop_front());
        mOutFlit  = f;
        mOutValid = 1'b1;
        if (!mLocked) begin
          mOwner = g;
          if (t == 2'b01) mLocked = 1'b1;
          else            mPtr = g;
        end else if (t == 2'b10) begin
          mLocked = 1'b0;
          mPtr    = mOwner;
        end
      end else if (out_ready) begin
        mOutValid = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < N; i++) holdOff[i] = randValid && ($urandom_range(0, 3) == 0);
    out_ready = randReady ? ($urandom_range(0, 3) != 0) : fixedReady;
    driveInputs();
  endtask

  task automatic runUntilEmpty(int budget, string tag);
    int n = 0;
    while (queuesBusy() && n < budget) begin
      applyStimulus();
      n++;
    end
    if (queuesBusy()) begin
      bad++;
      $error("[TB] FAIL %s_timeout observed=busy expected=drained", tag);
    end
  endtask

  task automatic applyReset();
    rst_sys_n = 1'b0;
    applyStimulus();
    rst_sys_n = 1'b1;
    grantLog.delete();
    xferCyc.delete();
    peSeen = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    driveInputs();
    @(posedge clk);
    #1;
    repeat (2) applyStimulus();
    rst_sys_n = 1'b1;
    applyStimulus();

    // SINGLE on port 0 appears one cycle later with both trace pulses.
    grantLog.delete();
    pushFlit(0, 2'b11, 32'h0000_0011);
    runUntilEmpty(10, "single");
    checkOutput("single_flit", out_flit, 34'h3_0000_0011);
    checkOutput("single_valid", out_valid, 1);
    checkOutput("single_trace", {trace_pkt_start, trace_pkt_end}, 2'b11);
    checkOutput("single_count", grantLog.size(), 1);
    applyStimulus();
    applyStimulus();

    // Two simultaneous 3-flit packets do not interleave and have no bubble.
    applyReset();
    for (int p = 0; p < 2; p++) begin
      pushFlit(p, 2'b01, 32'h100 + p);
      pushFlit(p, 2'b00, 32'h200 + p);
      pushFlit(p, 2'b10, 32'h300 + p);
    end
    runUntilEmpty(20, "pkt");
    checkOutput("pkt_count", grantLog.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput("pkt_grant", (grantLog.size() > i) ? grantLog[i] : -1, (i < 3) ? 0 : 1);
    checkOutput("pkt_rate", (xferCyc.size() == 6) ? xferCyc[5] - xferCyc[0] : -1, 5);
    applyStimulus();

    // SINGLE streams on all ports rotate 0,1,2 at one flit per cycle.
    applyReset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) pushFlit(p, 2'b11, 32'h1000 * (r + 1) + p);
    runUntilEmpty(20, "rr");
    for (int i = 0; i < 6; i++)
      checkOutput("rr_grant", (grantLog.size() > i) ? grantLog[i] : -1, i % 3);
    checkOutput("rr_rate", (xferCyc.size() == 6) ? xferCyc[5] - xferCyc[0] : -1, 5);
    applyStimulus();

    // Backpressure for 4 cycles mid-packet freezes the stage and all readies.
    applyReset();
    pushFlit(0, 2'b01, 32'hA0);
    pushFlit(0, 2'b00, 32'hA1);
    pushFlit(0, 2'b00, 32'hA2);
    pushFlit(0, 2'b00, 32'hA3);
    pushFlit(0, 2'b10, 32'hA4);
    pushFlit(1, 2'b11, 32'hB0);
    repeat (2) applyStimulus();
    fixedReady = 1'b0;
    out_ready  = 1'b0;
    repeat (4) applyStimulus();
    checkOutput("bp_frozen_flit", out_flit, mkFlit(2'b00, 32'hA1));
    checkOutput("bp_frozen_ready", in_ready, 0);
    fixedReady = 1'b1;
    out_ready  = 1'b1;
    runUntilEmpty(20, "bp");
    checkOutput("bp_stall", (xferCyc.size() > 2) ? xferCyc[2] - xferCyc[1] : -1, 5);
    for (int i = 0; i < 6; i++)
      checkOutput("bp_grant", (grantLog.size() > i) ? grantLog[i] : -1, (i < 5) ? 0 : 1);
    applyStimulus();

    // Stray PAYLOAD in IDLE is forwarded, flags proto_err, and does not lock.
    applyReset();
    pushFlit(1, 2'b00, 32'hDEAD_BEEF);
    runUntilEmpty(10, "proto");
    checkOutput("proto_flit", out_flit, 34'h0_DEAD_BEEF);
    pushFlit(2, 2'b11, 32'hC2);
    pushFlit(0, 2'b11, 32'hC0);
    runUntilEmpty(10, "proto_after");
    repeat (2) applyStimulus();
    checkOutput("proto_pulses", peSeen, 1);
    for (int i = 0; i < 3; i++)
      checkOutput("proto_grant", (grantLog.size() > i) ? grantLog[i] : -1, (i + 1) % 3);

    // Reset mid-packet drops the packet and restarts with port 0 first.
    applyReset();
    pushFlit(1, 2'b01, 32'hD0);
    pushFlit(1, 2'b00, 32'hD1);
    applyStimulus();
    pushFlit(0, 2'b11, 32'hE0);
    rst_sys_n = 1'b0;
    applyStimulus();
    rst_sys_n = 1'b1;
    checkOutput("rst_mid_valid", out_valid, 0);
    checkOutput("rst_mid_owner", owner, 0);
    grantLog.delete();
    peSeen = 0;
    runUntilEmpty(10, "rst_mid");
    repeat (2) applyStimulus();
    for (int i = 0; i < 2; i++)
      checkOutput("rst_mid_grant", (grantLog.size() > i) ? grantLog[i] : -1, i);
    checkOutput("rst_mid_proto", peSeen, 1);

    // Randomized packets, valid gaps and backpressure.
    applyReset();
    randValid = 1'b1;
    randReady = 1'b1;
    for (int p = 0; p < N; p++) begin
      for (int k = 0; k < 8; k++) begin
        int len;
        len = $urandom_range(1, 4);
        if (len == 1) begin
          pushFlit(p, ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b11, $urandom);
        end else begin
          pushFlit(p, 2'b01, $urandom);
          for (int j = 0; j < len - 2; j++) pushFlit(p, 2'b00, $urandom);
          pushFlit(p, 2'b10, $urandom);
        end
      end
    end
    runUntilEmpty(3000, "random");
    randValid  = 1'b0;
    randReady  = 1'b0;
    fixedReady = 1'b1;
    repeat (3) applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
